// File: rtl/uart_cmd_bridge_pkg.sv
// Shared constants and types for the UART command bridge.
// Holds the opcode and response byte values, the FSM state encodings and
// the bus request payload type. Used by the RTL and by the testbench.
package uart_cmd_bridge_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    // Command opcodes
    localparam logic [7:0] OP_WRITE    = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ     = 8'h52;  // 'R'

    // Response bytes
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'
    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_BUS   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    // Bus request payload held stable for the whole bus cycle
    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] adr;
        logic [WORD_W-1:0] dat;
    } wb_req_t;

    // Little-endian assembly: each new byte enters at the top, so after four
    // bytes the first one received sits in bits [7:0].
    function automatic logic [WORD_W-1:0] shift_in_byte(
        input logic [WORD_W-1:0] word,
        input logic [BYTE_W-1:0] b
    );
        return {b, word[WORD_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: turns byte commands from a UART receiver into 32-bit
// bus reads/writes and returns a response through a UART transmitter.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_valid, rx_data   received byte from UART
//   rx_ack              one-cycle pulse consuming the received byte
//   tx_valid, tx_data   byte offered to UART transmitter
//   tx_ready            transmitter accepting
//   wb_adr, wb_dat_w    bus address / write data
//   wb_we, wb_cyc       bus write enable / cycle+strobe
//   wb_dat_r, wb_ack    bus read data / cycle complete
module uart_cmd_bridge
    import uart_cmd_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic        wb_we,
    output logic        wb_cyc,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack
);

    // Counter only needs to reach TIMEOUT_CYCLES-1
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state,    state_d;
    logic [1:0]        cnt,      cnt_d;
    logic [TMO_W-1:0]  tmo,      tmo_d;
    logic              rx_ack_d;
    logic              tx_valid_d;
    logic [7:0]        tx_data_d;
    logic              wb_cyc_d;
    wb_req_t           req,      req_d;
    logic [WORD_W-1:0] resp,     resp_d;
    logic [1:0]        rlast,    rlast_d;
    logic              accept_c;

    // A byte is taken only if it was not acknowledged on the previous cycle
    assign accept_c = rx_valid && !rx_ack;

    assign wb_adr   = req.adr;
    assign wb_dat_w = req.dat;
    assign wb_we    = req.we;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 2'd0;
            tmo      <= '0;
            rx_ack   <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            wb_cyc   <= 1'b0;
            req      <= '0;
            resp     <= '0;
            rlast    <= 2'd0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            tmo      <= tmo_d;
            rx_ack   <= rx_ack_d;
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            wb_cyc   <= wb_cyc_d;
            req      <= req_d;
            resp     <= resp_d;
            rlast    <= rlast_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        tmo_d      = tmo;
        rx_ack_d   = 1'b0;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        wb_cyc_d   = wb_cyc;
        req_d      = req;
        resp_d     = resp;
        rlast_d    = rlast;

        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    rx_ack_d = 1'b1;
                    cnt_d    = 2'd0;
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        req_d.we  = (rx_data == OP_WRITE);
                        req_d.dat = '0;
                        state_d   = ST_ADDR;
                    end else begin
                        // Unknown opcode: single '?' response, then back to idle
                        resp_d  = {24'h0, RSP_UNKNOWN};
                        rlast_d = 2'd0;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (accept_c) begin
                    rx_ack_d  = 1'b1;
                    req_d.adr = shift_in_byte(req.adr, rx_data);
                    cnt_d     = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_d = req.we ? ST_WDATA : ST_BUS;
                    end
                end
            end

            ST_WDATA: begin
                if (accept_c) begin
                    rx_ack_d  = 1'b1;
                    req_d.dat = shift_in_byte(req.dat, rx_data);
                    cnt_d     = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_d = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                if (!wb_cyc) begin
                    // First cycle in BUS: open the cycle; any wb_ack here is stray
                    wb_cyc_d = 1'b1;
                    tmo_d    = '0;
                end else if (wb_ack) begin
                    // Ack takes priority over a timeout in the same cycle
                    wb_cyc_d = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = ST_RESP;
                    if (req.we) begin
                        resp_d  = {24'h0, RSP_OK};
                        rlast_d = 2'd0;
                    end else begin
                        resp_d  = wb_dat_r;
                        rlast_d = 2'd3;
                    end
                end else if (tmo == TMO_LAST) begin
                    wb_cyc_d = 1'b0;
                    cnt_d    = 2'd0;
                    resp_d   = {24'h0, RSP_ERR};
                    rlast_d  = 2'd0;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo + TMO_W'(1);
                end
            end

            ST_RESP: begin
                if (tx_valid) begin
                    if (tx_ready) begin
                        // Drop valid for at least one cycle between bytes
                        tx_valid_d = 1'b0;
                        resp_d     = resp >> BYTE_W;
                        cnt_d      = cnt + 2'd1;
                        if (cnt == rlast) begin
                            cnt_d   = 2'd0;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = resp[7:0];
                end
            end

            default: begin
                state_d  = ST_IDLE;
                wb_cyc_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles waited for o_ack before error.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_valid  input  1  UART has a received byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 rx_ack  output  1  one-cycle pulse consuming the byte.
REQ-007 tx_valid  output  1  byte offered to UART transmitter.
REQ-008 tx_data  output  8  byte to transmit.
REQ-009 tx_ready  input  1  UART transmitter idle and accepting.
REQ-010 wb_adr  output  32  bus address.
REQ-011 wb_dat_w  output  32  bus write data.
REQ-012 wb_we  output  1  bus write enable.
REQ-013 wb_cyc  output  1  bus cycle/strobe.
REQ-014 wb_dat_r  input  32  bus read data.
REQ-015 wb_ack  input  1  bus cycle complete.

Function
REQ-016 Command format SHALL be: opcode byte, 4 address bytes little-endian, then for writes 4 data bytes little-endian.
REQ-017 Opcode 0x57 ('W') SHALL perform a 32-bit bus write; opcode 0x52 ('R') a 32-bit bus read; any other opcode SHALL transmit 0x3F ('?') and return to IDLE.
REQ-018 FSM states SHALL be IDLE, ADDR, WDATA, BUS, RESP, each transition on one clock edge.
REQ-019 IDLE->ADDR on valid opcode; ADDR->WDATA after 4th address byte if write, ADDR->BUS if read; WDATA->BUS after 4th data byte; BUS->RESP on wb_ack or timeout; RESP->IDLE after last response byte accepted.
REQ-020 A byte SHALL be accepted when rx_valid=1 and no rx_ack was issued the previous cycle; rx_ack SHALL pulse exactly one cycle per accepted byte.
REQ-021 rx_valid SHALL be ignored in BUS and RESP; bytes remain unacknowledged until IDLE.
REQ-022 Byte counter SHALL be 2 bits, cleared on entry to ADDR and WDATA, wrapping 3->0 on state exit.
REQ-023 wb_cyc SHALL assert the cycle after entering BUS, hold with stable wb_adr/wb_dat_w/wb_we until wb_ack, and deassert the cycle after wb_ack.
REQ-024 Read data SHALL be captured from wb_dat_r in the wb_ack cycle.
REQ-025 Timeout counter SHALL count wb_cyc cycles; reaching TIMEOUT_CYCLES SHALL drop wb_cyc and respond 0x45 ('E') only.
REQ-026 wb_ack when wb_cyc=0 SHALL be ignored.
REQ-027 Write response SHALL be single byte 0x4B ('K'); read response SHALL be 4 data bytes, LSB first.
REQ-028 tx_valid SHALL hold with stable tx_data until a cycle with tx_valid=1 and tx_ready=1, then deassert for at least one cycle before next byte.
REQ-029 wb_ack and timeout in same cycle: wb_ack SHALL win.

Reset
REQ-030 On rst all outputs SHALL be 0 (rx_ack, tx_valid, tx_data, wb_cyc, wb_we, wb_adr, wb_dat_w), FSM IDLE, counters 0, asynchronously.
REQ-031 rst mid-command or mid-bus-cycle SHALL abandon it with no response; wb_cyc drops immediately.

Structure
REQ-032 Opcode and response byte constants and FSM state encodings SHALL live in a shared package/include used by bench and RTL.
REQ-033 Single flat module; it SHALL connect directly to corescore_emitter_uart handshake ports without glue.

Verification
REQ-034 Send 57 10 00 00 00 EF BE AD DE, wb_ack after 3 cycles -> one write, wb_adr=0x00000010, wb_dat_w=0xDEADBEEF, tx 0x4B.
REQ-035 Send 52 04 00 00 00, wb_dat_r=0x12345678 with ack -> tx 78 56 34 12 in order, wb_we=0.
REQ-036 Send 0x41 -> tx 0x3F, FSM IDLE, next valid command executes normally.
REQ-037 Read with wb_ack never asserted, TIMEOUT_CYCLES=8 -> wb_cyc high exactly 8 cycles, tx 0x45.
REQ-038 Assert rst after 3rd address byte -> outputs 0 immediately, no tx; fresh command then completes correctly.
REQ-039 Hold tx_ready low 50 cycles during read response -> tx_valid/tx_data stable throughout, no byte lost or duplicated.
